// File: rtl/alu_exec_if.sv
// Issue/result bundle between register-read and the execute-stage ALU.
// Issuer drives in_valid and holds op/operands stable until a cycle where in_valid && in_ready.
interface alu_exec_if #(
  parameter int N   = 16,
  parameter int SHW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     op;
  logic [N-1:0]   in_src;
  logic [N-1:0]   in_dst;
  logic [SHW-1:0] shamt;
  logic           out_valid;
  logic [N-1:0]   out;
  logic           carry_flag;
  logic           zero_flag;
  logic           neg_flag;

  modport master (
    output in_valid, op, in_src, in_dst, shamt,
    input  in_ready, out_valid, out, carry_flag, zero_flag, neg_flag
  );

  modport slave (
    input  in_valid, op, in_src, in_dst, shamt,
    output in_ready, out_valid, out, carry_flag, zero_flag, neg_flag
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with C/Z/N condition codes and iterative
// one-bit-per-cycle shifts that hold in_ready low while they run.
module alu_exec_unit #(
  parameter int N   = 16,
  parameter int SHW = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_exec_if.slave bus,
  output logic     dbgState
);
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpNot   = 4'd1;
  localparam logic [3:0] OpPassD = 4'd2;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpAnd   = 4'd5;
  localparam logic [3:0] OpOr    = 4'd6;
  localparam logic [3:0] OpShl   = 4'd7;
  localparam logic [3:0] OpShr   = 4'd8;
  localparam logic [3:0] OpSetC  = 4'd9;
  localparam logic [3:0] OpClrC  = 4'd10;

  state_t         stateQ, stateD;
  logic [N-1:0]   workQ;
  logic [SHW-1:0] cntQ;
  logic           leftQ;
  logic [N-1:0]   outQ;
  logic           outValidQ, cQ, zQ, nQ;

  logic           accept, startShift, lastStep;
  logic [N:0]     sum;
  logic [N-1:0]   res, stepVal;
  logic           resC, updC, updZN, stepOut;

  assign accept     = bus.in_valid && (stateQ == IDLE);
  assign startShift = ((bus.op == OpShl) || (bus.op == OpShr)) && (bus.shamt != '0);
  assign lastStep   = (stateQ == SHIFT) && (cntQ == SHW'(1));
  assign sum        = {1'b0, bus.in_src} + {1'b0, bus.in_dst};

  // One step of the running shift; the vacated end is zero-filled.
  assign stepVal = leftQ ? {workQ[N-2:0], 1'b0} : {1'b0, workQ[N-1:1]};
  assign stepOut = leftQ ? workQ[N-1] : workQ[0];

  always_comb begin
    res   = bus.in_src;
    resC  = cQ;
    updC  = 1'b0;
    updZN = 1'b0;
    case (bus.op)
      OpAdd:   begin res = sum[N-1:0]; resC = sum[N]; updC = 1'b1; updZN = 1'b1; end
      OpNot:   begin res = ~bus.in_src; updZN = 1'b1; end
      OpPassD: begin res = bus.in_dst; updZN = 1'b1; end
      OpSub:   begin
        res   = bus.in_dst - bus.in_src;
        resC  = bus.in_src > bus.in_dst;
        updC  = 1'b1;
        updZN = 1'b1;
      end
      OpAnd:   begin res = bus.in_src & bus.in_dst; updZN = 1'b1; end
      OpOr:    begin res = bus.in_src | bus.in_dst; updZN = 1'b1; end
      // Zero-distance shifts complete here and leave C alone.
      OpShl, OpShr: begin res = bus.in_dst; updZN = 1'b1; end
      OpSetC:  begin res = bus.in_dst; resC = 1'b1; updC = 1'b1; end
      OpClrC:  begin res = bus.in_dst; resC = 1'b0; updC = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (accept && startShift) stateD = SHIFT;
      SHIFT:   if (lastStep) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateD;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      workQ     <= '0;
      cntQ      <= '0;
      leftQ     <= 1'b0;
      outQ      <= '0;
      outValidQ <= 1'b0;
      cQ        <= 1'b0;
      zQ        <= 1'b0;
      nQ        <= 1'b0;
    end else begin
      outValidQ <= 1'b0;
      if (stateQ == SHIFT) begin
        workQ <= stepVal;
        cntQ  <= cntQ - SHW'(1);
        if (lastStep) begin
          outQ      <= stepVal;
          cQ        <= stepOut;
          zQ        <= (stepVal == '0);
          nQ        <= stepVal[N-1];
          outValidQ <= 1'b1;
        end
      end else if (accept) begin
        if (startShift) begin
          workQ <= bus.in_dst;
          cntQ  <= bus.shamt;
          leftQ <= (bus.op == OpShl);
        end else begin
          outQ      <= res;
          outValidQ <= 1'b1;
          if (updC) cQ <= resC;
          if (updZN) begin
            zQ <= (res == '0);
            nQ <= res[N-1];
          end
        end
      end
    end
  end

  assign bus.in_ready   = (stateQ == IDLE);
  assign bus.out_valid  = outValidQ;
  assign bus.out        = outQ;
  assign bus.carry_flag = cQ;
  assign bus.zero_flag  = zQ;
  assign bus.neg_flag   = nQ;
  assign dbgState       = stateQ;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, registered execute-stage ALU for the pipelined processor.
- Adds an architectural condition-code register (C, Z, N) with per-op update rules.
- Adds a valid/ready input handshake and multi-cycle iterative shifts that stall the issuing stage.
- Sits between decode/register-read and the EX/MEM pipeline register.

Parameters:
- N, 16, datapath width in bits.
- SHW, 4, width of the shift-amount input.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  4  operation code.
- in_src  in  N  source operand.
- in_dst  in  N  destination operand.
- shamt  in  SHW  shift amount; used by SHL and SHR only.
- out_valid  out  1  one-cycle pulse: result valid.
- out  out  N  registered result.
- carry_flag  out  1  registered C.
- zero_flag  out  1  registered Z.
- neg_flag  out  1  registered N.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: out=0, out_valid=0, C=Z=N=0, state=IDLE, in_ready=1.
- Acceptance: an op is accepted on a rising edge where in_valid && in_ready. in_ready = (state==IDLE).
- Operations (C/Z/N columns give flag effect; "-" = unchanged; Z and N are computed from the result):
  - 0 ADD: {C,out} = src+dst, (N+1)-bit sum. Flags: C, Z, N.
  - 1 NOT: out = ~src. Flags: -, Z, N.
  - 2 PASSD: out = dst. Flags: -, Z, N.
  - 3 PASSS: out = src. Flags: -, -, -.
  - 4 SUB: out = dst-src; C=1 iff src>dst (borrow). Flags: C, Z, N.
  - 5 AND: out = src&dst. Flags: -, Z, N.
  - 6 OR: out = src|dst. Flags: -, Z, N.
  - 7 SHL: out = dst shifted left shamt places. Flags: C, Z, N.
  - 8 SHR (logical): out = dst shifted right shamt places. Flags: C, Z, N.
  - 9 SETC: out = dst. C=1; Z, N unchanged.
  - 10 CLRC: out = dst. C=0; Z, N unchanged.
  - 11-15: treated as PASSS. No flag change.
- Single-cycle ops (everything except SHL/SHR with shamt>0):
  - out and flags are registered on the accepting edge.
  - out_valid is high for exactly the following cycle.
  - Back-to-back issue is allowed at 1 op/cycle.
- Shifts with shamt=k>0:
  - Accepting edge E0: latch dst into a working register, k into a down-counter; state goes IDLE->SHIFT; in_ready drops.
  - Edges E1..Ek: shift one bit per edge (zero fill). Cshift = bit shifted out on that step (MSB for SHL, LSB for SHR).
  - Edge Ek: load out and flags, state goes SHIFT->IDLE, out_valid pulses one cycle, in_ready returns high in that same cycle.
  - k>=N: natural result out=0. C = bit shifted out on the final step, which is 0 when k>N.
- Shifts with shamt=0: single-cycle; out=dst; C unchanged; Z and N updated.
- Registered outputs: out and flags hold their values between operations; out_valid is low when no result is produced.
- Inputs while busy: in_valid is ignored while in_ready=0. The issuer must hold the op stable until acceptance.
- Reset mid-shift: the op is aborted, no out_valid is produced, all state returns to reset values.
- Reset dominates acceptance on the same edge.

Test Plan:
- ADD src=0xFFFF, dst=0x0001 -> next cycle: out=0x0000, out_valid=1, C=1, Z=1, N=0.
- SUB dst=0x0003, src=0x0005, then PASSS src=0x1234 on the next cycle -> first result out=0xFFFE, C=1, Z=0, N=1; PASSS gives out=0x1234 with C/Z/N still 1/0/1.
- SHL dst=0x8001, shamt=3 -> in_ready low for 3 cycles; then out=0x0008, C=0, Z=0, N=0, out_valid for one cycle. A second op held on in_valid is accepted only when in_ready returns high.
- SHR dst=0x0003, shamt=2 -> out=0x0000, C=1, Z=1, N=0 after a 2-cycle stall. Same op with shamt=0 -> 1 cycle, out=0x0003, C unchanged.
- SETC, then NOT src=0x0000, then CLRC -> C=1 after SETC; NOT gives out=0xFFFF, N=1, Z=0, C still 1; CLRC clears C only.
- Assert rst=0 during cycle 2 of SHL with shamt=10 -> no out_valid; out=0, all flags 0, in_ready=1 on release. A subsequent ADD executes normally.
